// File: rtl/weight_cell_pkg.sv
// Shared helpers for the weight compute cell family: result-bus layout and
// the zero-point product used by every cell generation.
package weight_cell_pkg;

  function automatic int result_bus_width(input int result_width);
    return result_width + 1;
  endfunction

  // Valid flag sits directly above the result payload.
  function automatic int result_valid_bit(input int result_width);
    return result_width;
  endfunction

  function automatic longint zp_product(input longint value, input longint weight,
                                        input longint value_offset,
                                        input longint weight_offset);
    return (value - value_offset) * (weight - weight_offset);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding finished results until a chain slot frees up.
// A push while full is accepted only if a pop happens on the same edge.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_mac_cell.sv
// One systolic PE: forwards indexed beats, accumulates zero-point products per
// vector and inserts finished dot products into the first empty chain slot.
module weight_mac_cell
  import weight_cell_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int RESULT_WIDTH  = 32,
  parameter int INDEX_WIDTH   = 18,
  parameter int WEIGHT_AMOUNT = 2,
  parameter int WEIGHT_OFFSET = 1,
  parameter int INPUT_OFFSET  = 2,
  parameter logic [WEIGHT_AMOUNT*WEIGHT_WIDTH-1:0] WEIGHTS = {8'd4, 8'd1},
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    weight_load_en,
  input  logic [((WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1)-1:0] weight_load_addr,
  input  logic [WEIGHT_WIDTH-1:0] weight_load_data,
  input  logic                    input_enable,
  input  logic [INDEX_WIDTH-1:0]  input_index,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic                    input_last,
  input  logic [RESULT_WIDTH:0]   input_result,
  output logic                    output_enable,
  output logic [INDEX_WIDTH-1:0]  output_index,
  output logic [DATA_WIDTH-1:0]   output_value,
  output logic                    output_last,
  output logic [RESULT_WIDTH:0]   output_result,
  output logic                    overflow
);
  localparam int ADDR_W    = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
  localparam int BUS_W     = result_bus_width(RESULT_WIDTH);
  localparam int VALID_BIT = result_valid_bit(RESULT_WIDTH);
  localparam logic [INDEX_WIDTH-1:0] AMOUNT_IDX  = INDEX_WIDTH'(WEIGHT_AMOUNT);
  localparam logic [ADDR_W:0]        AMOUNT_ADDR = (ADDR_W + 1)'(WEIGHT_AMOUNT);

  logic [WEIGHT_WIDTH-1:0] weights [WEIGHT_AMOUNT];
  logic [RESULT_WIDTH-1:0] acc, product, acc_sum, head;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    index_hit, push, pop, full, empty;

  assign index_hit = (input_index < AMOUNT_IDX);
  assign rd_addr   = input_index[ADDR_W-1:0];

  always_comb begin
    product = '0;
    if (input_enable && index_hit)
      product = RESULT_WIDTH'(zp_product(longint'(input_value), longint'(weights[rd_addr]),
                                         longint'(INPUT_OFFSET), longint'(WEIGHT_OFFSET)));
  end

  assign acc_sum = acc + product;
  assign push    = input_enable && input_last;
  assign pop     = !input_result[VALID_BIT] && !empty;

  result_fifo #(.WIDTH(RESULT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (acc_sum),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WEIGHT_AMOUNT; i++)
        weights[i] <= WEIGHTS[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      acc           <= '0;
      overflow      <= 1'b0;
      output_enable <= 1'b0;
      output_index  <= '0;
      output_value  <= '0;
      output_last   <= 1'b0;
      output_result <= '0;
    end else begin
      // Beats this cycle read the old weight; the write lands on this edge.
      if (weight_load_en && ({1'b0, weight_load_addr} < AMOUNT_ADDR))
        weights[weight_load_addr] <= weight_load_data;
      if (input_enable) acc <= input_last ? '0 : acc_sum;
      if (push && full && !pop) overflow <= 1'b1;
      output_enable <= input_enable;
      output_index  <= input_index;
      output_value  <= input_value;
      output_last   <= input_last;
      output_result <= pop ? BUS_W'({1'b1, head}) : input_result;
    end
  end

endmodule

// File: tb/tb_weight_mac_cell.sv
// Directed bench for weight_mac_cell with hand-computed expected results.
module tb_weight_mac_cell;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        weight_load_en;
  logic [0:0]  weight_load_addr;
  logic [7:0]  weight_load_data;
  logic        input_enable;
  logic [17:0] input_index;
  logic [15:0] input_value;
  logic        input_last;
  logic [32:0] input_result;
  logic        output_enable;
  logic [17:0] output_index;
  logic [15:0] output_value;
  logic        output_last;
  logic [32:0] output_result;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  weight_mac_cell dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .weight_load_en   (weight_load_en),
    .weight_load_addr (weight_load_addr),
    .weight_load_data (weight_load_data),
    .input_enable     (input_enable),
    .input_index      (input_index),
    .input_value      (input_value),
    .input_last       (input_last),
    .input_result     (input_result),
    .output_enable    (output_enable),
    .output_index     (output_index),
    .output_value     (output_value),
    .output_last      (output_last),
    .output_result    (output_result),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [17:0] idx, input logic [15:0] val, input logic last);
    input_enable = 1'b1;
    input_index  = idx;
    input_value  = val;
    input_last   = last;
    step();
    input_enable = 1'b0;
    input_last   = 1'b0;
  endtask

  task automatic idle();
    input_enable = 1'b0;
    input_last   = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    idle();
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    weight_load_en = 1'b0; weight_load_addr = '0; weight_load_data = '0;
    input_enable = 1'b0; input_index = '0; input_value = '0; input_last = 1'b0;
    input_result = '0;

    // 1: reset holds everything at zero, even with a beat and valid chain driven
    step();
    input_result = {1'b1, 32'd55};
    input_enable = 1'b1; input_index = 18'd1; input_value = 16'd4; input_last = 1'b1;
    step(); step();
    chk("rst_enable", output_enable, 0);
    chk("rst_value", output_value, 0);
    chk("rst_last", output_last, 0);
    chk("rst_result", output_result, 0);
    chk("rst_overflow", overflow, 0);
    input_enable = 1'b0; input_last = 1'b0; input_result = '0;
    reset_n = 1'b1;
    idle(); idle();
    chk("rst_no_result", output_result, 0);

    // 2: basic vector, 6 + 0 + 12 = 18
    beat(18'd1, 16'd4, 1'b0);
    chk("pt_enable", output_enable, 1);
    chk("pt_index", output_index, 1);
    chk("pt_value", output_value, 4);
    chk("pt_last0", output_last, 0);
    beat(18'd0, 16'd5, 1'b0);
    chk("pt_index0", output_index, 0);
    beat(18'd1, 16'd6, 1'b1);
    chk("pt_last1", output_last, 1);
    chk("v18_not_early", output_result, 0);
    idle();
    chk("pt_idle", output_enable, 0);
    chk("v18", output_result, {1'b1, 32'd18});
    idle();
    chk("v18_single", output_result, 0);

    // 3: negative product (0-2)*(4-1) = -6
    beat(18'd1, 16'd0, 1'b1);
    idle();
    chk("neg6", output_result, {1'b1, 32'hFFFF_FFFA});

    // 4: weight loads; same-cycle beat sees the old weight
    weight_load_en = 1'b1; weight_load_addr = 1'b0; weight_load_data = 8'd9;
    idle();
    weight_load_en = 1'b0;
    beat(18'd0, 16'd3, 1'b1);
    idle();
    chk("load_w0", output_result, {1'b1, 32'd8});
    weight_load_en = 1'b1; weight_load_addr = 1'b1; weight_load_data = 8'd7;
    beat(18'd1, 16'd4, 1'b1);
    weight_load_en = 1'b0;
    idle();
    chk("load_same_cycle", output_result, {1'b1, 32'd6});
    beat(18'd3, 16'd100, 1'b0);
    beat(18'd1, 16'd4, 1'b1);
    idle();
    chk("new_w1_oob_idx", output_result, {1'b1, 32'd12});

    // 5: busy chain for 6 cycles, two vectors queue up then drain in order
    do_reset();
    input_result = {1'b1, 32'd55};
    beat(18'd1, 16'd4, 1'b0);
    chk("busy5_a", output_result, {1'b1, 32'd55});
    beat(18'd0, 16'd5, 1'b0);
    beat(18'd1, 16'd6, 1'b1);
    beat(18'd1, 16'd4, 1'b1);
    chk("busy5_b", output_result, {1'b1, 32'd55});
    idle(); idle();
    chk("busy5_c", output_result, {1'b1, 32'd55});
    input_result = '0;
    idle();
    chk("drain5_18", output_result, {1'b1, 32'd18});
    idle();
    chk("drain5_6", output_result, {1'b1, 32'd6});
    idle();
    chk("drain5_empty", output_result, 0);
    chk("ovf5", overflow, 0);

    // 6: three vectors into a depth-2 FIFO, third is dropped
    input_result = {1'b1, 32'd55};
    beat(18'd1, 16'd4, 1'b0);
    beat(18'd0, 16'd5, 1'b0);
    beat(18'd1, 16'd6, 1'b1);
    beat(18'd1, 16'd4, 1'b1);
    beat(18'd1, 16'd0, 1'b1);
    idle();
    chk("busy6", output_result, {1'b1, 32'd55});
    chk("ovf6", overflow, 1);
    input_result = '0;
    idle();
    chk("drain6_18", output_result, {1'b1, 32'd18});
    idle();
    chk("drain6_6", output_result, {1'b1, 32'd6});
    idle();
    chk("drain6_dropped", output_result, 0);
    chk("ovf6_sticky", overflow, 1);

    // 7: reset mid-vector discards partial sum and restores weights
    weight_load_en = 1'b1; weight_load_addr = 1'b1; weight_load_data = 8'd7;
    idle();
    weight_load_en = 1'b0;
    beat(18'd1, 16'd4, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_ovf_clear", overflow, 0);
    chk("async_pt_clear", output_index, 0);
    idle();
    reset_n = 1'b1;
    idle(); idle(); idle();
    chk("mid_rst_no_result", output_result, 0);
    beat(18'd1, 16'd4, 1'b1);
    idle();
    chk("weights_reverted", output_result, {1'b1, 32'd6});
    beat(18'd0, 16'd3, 1'b1);
    idle();
    chk("w0_reverted", output_result, {1'b1, 32'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_mac_cell.md
Name: weight_mac_cell

Overview:
- Parametrised successor to the fixed-weight compute cell: one processing element of a systolic quantised matrix-vector engine.
- Streams indexed input values through to the next cell and multiplies each value by a weight selected by its index, using zero-point (offset) arithmetic.
- Accumulates one dot product per vector, terminated by a last flag, and inserts each finished result into a shared result chain at the first empty slot.
- Adds over the previous generation: run-time loadable weights, a signed accumulator, vector framing, a result FIFO and an overflow flag.

Parameters:
- DATA_WIDTH, 16, width of input_value.
- WEIGHT_WIDTH, 8, width of each stored weight.
- RESULT_WIDTH, 32, accumulator/result width; the result bus carries one extra valid bit on top.
- INDEX_WIDTH, 18, width of input_index.
- WEIGHT_AMOUNT, 2, number of weights stored in this cell.
- WEIGHT_OFFSET, 1, weight zero-point, subtracted from every weight.
- INPUT_OFFSET, 2, input zero-point, subtracted from every value.
- WEIGHTS, {8'd4, 8'd1}, reset contents; entry i sits at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- FIFO_DEPTH, 2, number of finished results held while waiting for a chain slot (>=1).

Ports:
- clk  in  1  clock; everything sampled on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- weight_load_en  in  1  write strobe for the weight store.
- weight_load_addr  in  clog2(WEIGHT_AMOUNT)  weight address to write.
- weight_load_data  in  WEIGHT_WIDTH  weight value to write.
- input_enable  in  1  input beat valid.
- input_index  in  INDEX_WIDTH  selects which weight the beat uses.
- input_value  in  DATA_WIDTH  unsigned activation.
- input_last  in  1  marks the final beat of a vector.
- input_result  in  RESULT_WIDTH+1  upstream result chain; MSB is the valid bit.
- output_enable, output_index, output_value, output_last  out  same widths as inputs  registered pass-through to the next cell.
- output_result  out  RESULT_WIDTH+1  downstream result chain.
- overflow  out  1  sticky: a finished result was dropped.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs go to 0.
  - Accumulator is cleared, the FIFO is emptied and overflow is cleared.
  - The weight store reloads from WEIGHTS.
- Pass-through: output_enable, output_index, output_value and output_last equal their inputs delayed by exactly one cycle. They are forwarded unchanged whether or not the index hits this cell.
- Product:
  - When input_enable=1 and input_index<WEIGHT_AMOUNT: p = (value−INPUT_OFFSET)·(weight[index]−WEIGHT_OFFSET).
  - Both operands are signed, one bit wider than their source.
  - The product is sign-extended or truncated to RESULT_WIDTH.
  - An index >= WEIGHT_AMOUNT contributes p=0; this is not an error.
- Accumulation: acc <= acc+p, wrapping modulo 2^RESULT_WIDTH. Beats with input_enable=0 leave acc unchanged, including input_last.
- End of vector: on a beat with input_enable=1 and input_last=1:
  - acc+p is pushed into the FIFO.
  - acc is cleared to 0 on the same edge, so a new vector may start on the very next cycle.
- FIFO full: if the FIFO is full when a push is requested and no pop occurs on the same edge, the result is dropped and overflow is set to 1 until reset. Pop and push on the same edge are both honoured.
- Chain insertion, each cycle:
  - If input_result[MSB]=0 and the FIFO is non-empty: output_result <= {1'b1, FIFO head} and the head is popped.
  - Otherwise output_result <= input_result.
  - Upstream valid results are never overwritten or reordered.
- Latency: with an empty chain and an empty FIFO, the result appears on output_result two cycles after its last beat is sampled.
- Weight load:
  - On weight_load_en=1, weight[addr] <= data; an out-of-range addr is ignored.
  - A beat in the same cycle uses the old weight; the new weight takes effect from the next cycle.
  - Loading is allowed mid-vector.
- Reset mid-vector: the partial acc and all queued results are discarded; nothing is emitted.

Decomposition:
- Shared package weight_cell_pkg:
  - Result-bus valid-bit position constant.
  - Result width helper.
  - Zero-point product function, reused by every cell generation.
- One sub-module, result_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, async active-low reset, push/pop/full/empty ports, and simultaneous push+pop when full.

Test Plan:
All scenarios use default parameters unless stated otherwise.
1. Hold reset_n=0 while clk runs → all outputs 0 and overflow=0. Drive a beat during reset → nothing propagates.
2. Beats (1,4),(0,5),(1,6,last) with input_result=0 → output_result={1,32'd18} (6+0+12) two cycles after the last beat; pass-through outputs lag inputs by 1.
3. Beat (1,0,last) → output_result={1,32'hFFFFFFFA} (−2·3=−6).
4. Load addr0=9, then beat (0,3,last) → {1,32'd8}. Load addr1=7 in the same cycle as beat (1,4,last) → old weight used, giving {1,32'd6}.
5. Hold input_result={1,32'd55} valid for 6 cycles while finishing two vectors (results 18 and 6) → output_result carries 55 throughout, then {1,18} and {1,6}, in order, in the first two empty slots; overflow=0.
6. Same as scenario 5 but finishing three vectors → overflow=1, the third result is dropped, the first two still emerge in order.
7. Deassert reset_n mid-vector after beat (1,4) → no result is ever emitted and the weights revert to WEIGHTS.
